// File: rtl/seq_mul8_if.sv
// -----------------------------------------------------------------------------
// seq_mul8_if -- operand/product handshake bundle for seq_mul8.
//
// Signals:
//   in_valid  : producer has operands on m/n
//   in_ready  : multiplier can accept operands
//   m, n      : 8-bit unsigned multiplicand / multiplier
//   out_valid : mul holds a completed product
//   out_ready : consumer accepts the product
//   mul       : 16-bit unsigned product
//   busy      : multiplier is iterating
//
// Modports:
//   master : the side that supplies operands and consumes products
//   slave  : the multiplier itself
// -----------------------------------------------------------------------------
interface seq_mul8_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  m;
  logic [7:0]  n;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] mul;
  logic        busy;

  modport master (
    output in_valid, m, n, out_ready,
    input  in_ready, out_valid, mul, busy
  );

  modport slave (
    input  in_valid, m, n, out_ready,
    output in_ready, out_valid, mul, busy
  );
endinterface

// File: rtl/seq_mul8.sv
// -----------------------------------------------------------------------------
// seq_mul8 -- 8x8 unsigned shift-and-add multiplier, one partial product per
// clock, with valid/ready handshakes on both the operand and product sides.
//
// Ports:
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous, active-high reset (wins over any handshake)
//   bus : seq_mul8_if.slave
//         in_valid/in_ready/m/n     operand handshake (accepted only in IDLE)
//         out_valid/out_ready/mul   product handshake (held in DONE)
//         busy                      high exactly while iterating (CALC)
//
// Configuration:
//   SEQ_MUL8_EARLY_EXIT_EN : when defined, CALC ends as soon as the remaining
//                            multiplier bits are all zero (1..8 cycles);
//                            otherwise CALC always takes 8 cycles.
//                            The product is the same in both builds.
// -----------------------------------------------------------------------------
module seq_mul8 (
  input  logic        clk,
  input  logic        rst,
  seq_mul8_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;

  logic [15:0] mcand_q;      // multiplicand, shifted left once per CALC edge
  logic [7:0]  mplier_q;     // multiplier, shifted right once per CALC edge
  logic [15:0] acc_q;        // running sum of partial products
  logic [2:0]  cnt_q;        // CALC iteration counter
  logic [15:0] mul_q;        // last delivered product

  logic [15:0] acc_sum;      // accumulator value after this edge's add
  logic [7:0]  mplier_shift; // multiplier value after this edge's shift
  logic        calc_last;    // this CALC edge is the final iteration

  // Partial product for the current multiplier LSB; all at 16 bits, so the
  // largest product (FF*FF = FE01) cannot overflow.
  assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shift = mplier_q >> 1;

`ifdef SEQ_MUL8_EARLY_EXIT_EN
  // Once the remaining multiplier bits are zero no further additions can
  // happen, so the accumulator already holds the final product. The counter
  // term never fires first; it only bounds the iteration count explicitly.
  assign calc_last = (mplier_shift == 8'h00) || (cnt_q == 3'd7);
`else
  assign calc_last = (cnt_q == 3'd7);
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:    if (calc_last)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore: depends on state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      CALC:    bus.busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.mul = mul_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset, not just the FSM, because mul is
  // architecturally visible and must read zero after reset; an aborted
  // operation therefore leaves no stale partial result behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      acc_q    <= 16'h0000;
      cnt_q    <= 3'd0;
      mul_q    <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          // Operands are captured only here; m/n are ignored afterwards.
          if (bus.in_valid) begin
            mcand_q  <= {8'h00, bus.m};
            mplier_q <= bus.n;
            acc_q    <= 16'h0000;
            cnt_q    <= 3'd0;
          end
        end
        CALC: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shift;
          cnt_q    <= cnt_q + 3'd1;
          // Load the product on the edge that enters DONE, including this
          // edge's own partial product.
          if (calc_last) begin
            mul_q <= acc_sum;
          end
        end
        default: ;  // DONE: mul_q holds until the next DONE entry
      endcase
    end
  end

endmodule
